// File: rtl/uart_coef_loader.sv
// rtl/uart_coef_loader.sv - coefficient-load frame parser with shadow buffer, commit and ACK/NAK reply
// Sits between uart_receive and uart_sender; drives the FIR coefficient bank.
module uart_coef_loader #(
  parameter int          NUM_COEF    = 16,
  parameter int          COEF_W      = 16,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15,
  parameter int          TIMEOUT_CYC = 5_000_000
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         tx_busy,
  output logic                         tx_en,
  output logic [7:0]                   tx_data,
  output logic [NUM_COEF*COEF_W-1:0]   coef_bus,
  output logic                         coef_load,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BUS_W = NUM_COEF * COEF_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA_H, S_DATA_L, S_CSUM, S_COMMIT, S_RESP
  } state_t;

  // Reply phases: wait for a free sender, wait for it to start, wait for it to finish.
  typedef enum logic [1:0] {
    R_SEND, R_WAIT_HI, R_WAIT_LO
  } resp_t;

  state_t              state_q, state_d;
  resp_t               resp_q, resp_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic [7:0]          hi_q, hi_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [COEF_W-1:0]   shadow_q [NUM_COEF];
  logic [COEF_W-1:0]   shadow_d [NUM_COEF];
  logic [BUS_W-1:0]    coef_bus_q, coef_bus_d;
  logic                coef_load_q, coef_load_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                frame_err_q, frame_err_d;

  logic                in_frame;
  logic                timeout_hit;
  logic                go_resp;
  logic                resp_nak;
  logic [15:0]         rx_word;
  logic [8:0]          len_end;
  logic [8:0]          commit_lo;
  logic [8:0]          commit_hi;

  assign in_frame    = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_DATA_H) ||
                       (state_q == S_DATA_L) || (state_q == S_CSUM);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = in_frame && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign rx_word     = {hi_q, rx_data};
  assign len_end     = {1'b0, addr_q} + {1'b0, rx_data};
  assign commit_lo   = {1'b0, addr_q};
  assign commit_hi   = {1'b0, addr_q} + {1'b0, len_q};

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    xor_d       = xor_q;
    hi_d        = hi_q;
    tmo_d       = '0;
    shadow_d    = shadow_q;
    coef_bus_d  = coef_bus_q;
    coef_load_d = 1'b0;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    frame_err_d = 1'b0;
    go_resp     = 1'b0;
    resp_nak    = 1'b0;

    if (in_frame) begin
      tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == HDR_BYTE)) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          xor_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          xor_d = xor_q ^ rx_data;
          len_d = rx_data;
          if ((rx_data == 8'd0) || (len_end > 9'(NUM_COEF))) begin
            go_resp  = 1'b1;
            resp_nak = 1'b1;
          end else begin
            idx_d   = addr_q;
            cnt_d   = rx_data;
            state_d = S_DATA_H;
          end
        end
      end
      S_DATA_H: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = S_DATA_L;
        end
      end
      S_DATA_L: begin
        if (rx_valid) begin
          xor_d = xor_q ^ rx_data;
          for (int i = 0; i < NUM_COEF; i++) begin
            if (idx_q == 8'(i)) begin
              shadow_d[i] = rx_word[COEF_W-1:0];
            end
          end
          idx_d   = idx_q + 8'd1;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_CSUM : S_DATA_H;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == xor_q) begin
            state_d = S_COMMIT;
          end else begin
            go_resp  = 1'b1;
            resp_nak = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < NUM_COEF; i++) begin
          if ((9'(i) >= commit_lo) && (9'(i) < commit_hi)) begin
            coef_bus_d[i*COEF_W +: COEF_W] = shadow_q[i];
          end
        end
        coef_load_d = 1'b1;
        go_resp     = 1'b1;
      end
      S_RESP: begin
        case (resp_q)
          R_SEND: begin
            if (!tx_busy) begin
              tx_en_d = 1'b1;
              resp_d  = R_WAIT_HI;
            end
          end
          R_WAIT_HI: begin
            if (tx_busy) begin
              resp_d = R_WAIT_LO;
            end
          end
          default: begin
            if (!tx_busy) begin
              state_d = S_IDLE;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      go_resp  = 1'b1;
      resp_nak = 1'b1;
    end

    // Reply byte is latched on entry so it is stable well before tx_en.
    if (go_resp) begin
      state_d     = S_RESP;
      resp_d      = R_SEND;
      tx_data_d   = resp_nak ? NAK_BYTE : ACK_BYTE;
      frame_err_d = resp_nak;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      resp_q      <= R_SEND;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      xor_q       <= '0;
      hi_q        <= '0;
      tmo_q       <= '0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= '0;
      end
      coef_bus_q  <= '0;
      coef_load_q <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      hi_q        <= hi_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      coef_bus_q  <= coef_bus_d;
      coef_load_q <= coef_load_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign coef_bus  = coef_bus_q;
  assign coef_load = coef_load_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;

endmodule
